// File: rtl/fix_ari_pkg.sv
// Shared definitions for the fixed-point add/sub pipeline: opcode encodings and
// saturation bound helpers for a signed lane of a given width.
package fix_ari_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_RSUB = 2'b10;
    localparam logic [1:0] OP_AVG  = 2'b11;

    // Bounds are returned 33 bits wide so any lane width up to 32 fits with headroom.
    function automatic logic signed [32:0] sat_max(input int data);
        return (33'sd1 <<< (data - 1)) - 33'sd1;
    endfunction

    function automatic logic signed [32:0] sat_min(input int data);
        return -(33'sd1 <<< (data - 1));
    endfunction

endpackage

// File: rtl/fix_ari_sat_lane.sv
// One signed lane: stage 1 computes the exact DATA+1-bit sum/difference,
// stage 2 clamps it (or halves it for AVG) and reports saturation.
module fix_ari_sat_lane
    import fix_ari_pkg::*;
#(
    parameter int DATA = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [1:0]      op,
    input  logic [DATA-1:0] a,
    input  logic [DATA-1:0] b,
    output logic [DATA-1:0] res,
    output logic            sat
);

    localparam logic signed [32:0]   MAX_W = sat_max(DATA);
    localparam logic signed [32:0]   MIN_W = sat_min(DATA);
    localparam logic signed [DATA:0] MAX_X = MAX_W[DATA:0];
    localparam logic signed [DATA:0] MIN_X = MIN_W[DATA:0];

    logic signed [DATA:0] ax_s;
    logic signed [DATA:0] bx_s;
    logic signed [DATA:0] sum_s;
    logic signed [DATA:0] sum_r;
    logic [1:0]           op_r;
    logic [DATA-1:0]      res_s;
    logic                 sat_s;

    assign ax_s = {a[DATA-1], a};
    assign bx_s = {b[DATA-1], b};

    // Stage 1 arithmetic; one extra bit keeps every result exact.
    always_comb begin
        sum_s = ax_s + bx_s;
        case (op)
            OP_ADD:  sum_s = ax_s + bx_s;
            OP_SUB:  sum_s = ax_s - bx_s;
            OP_RSUB: sum_s = bx_s - ax_s;
            OP_AVG:  sum_s = ax_s + bx_s;
            default: sum_s = ax_s + bx_s;
        endcase
    end

    // Stage 1 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r <= '0;
            op_r  <= OP_ADD;
        end else if (en) begin
            sum_r <= sum_s;
            op_r  <= op;
        end else begin
            sum_r <= sum_r;
            op_r  <= op_r;
        end
    end

    // Stage 2 clamp; AVG takes bits [DATA:1], i.e. the floor of sum/2, which always fits.
    always_comb begin
        res_s = sum_r[DATA-1:0];
        sat_s = 1'b0;
        if (op_r == OP_AVG) begin
            res_s = sum_r[DATA:1];
        end else if (sum_r > MAX_X) begin
            res_s = MAX_X[DATA-1:0];
            sat_s = 1'b1;
        end else if (sum_r < MIN_X) begin
            res_s = MIN_X[DATA-1:0];
            sat_s = 1'b1;
        end else begin
            res_s = sum_r[DATA-1:0];
        end
    end

    // Stage 2 output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            res <= '0;
            sat <= 1'b0;
        end else if (en) begin
            res <= res_s;
            sat <= sat_s;
        end else begin
            res <= res;
            sat <= sat;
        end
    end

endmodule

// File: rtl/fix_ari_addsub_pipe.sv
// Multi-lane 2-stage saturating fixed-point add/sub/rsub/avg unit with a shared
// valid/ready handshake, sticky saturation flag and saturating event counter.
module fix_ari_addsub_pipe
    import fix_ari_pkg::*;
#(
    parameter int DATA  = 16,
    parameter int LANES = 4,
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            op,
    input  logic [LANES*DATA-1:0] data_in1,
    input  logic [LANES*DATA-1:0] data_in2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*DATA-1:0] data_out,
    output logic [LANES-1:0]      sat_lanes,
    output logic                  sat_flag,
    input  logic                  sat_clr,
    output logic [CNTW-1:0]       sat_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic en_s;
    logic v1_r;
    logic v2_r;
    logic deliver_s;

    assign en_s      = !v2_r || out_ready;
    assign in_ready  = en_s;
    assign out_valid = v2_r;
    assign deliver_s = v2_r && out_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fix_ari_sat_lane #(.DATA(DATA)) u_lane (
            .clk (clk),
            .rst (rst),
            .en  (en_s),
            .op  (op),
            .a   (data_in1[i*DATA +: DATA]),
            .b   (data_in2[i*DATA +: DATA]),
            .res (data_out[i*DATA +: DATA]),
            .sat (sat_lanes[i])
        );
    end

    // Valid pipeline; a bubble simply travels as a zero valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
        end else if (en_s) begin
            v1_r <= in_valid;
            v2_r <= v1_r;
        end else begin
            v1_r <= v1_r;
            v2_r <= v2_r;
        end
    end

    // Sticky flag and counter; a clear wins over a same-cycle saturated delivery.
    always_ff @(posedge clk) begin
        if (rst || sat_clr) begin
            sat_flag <= 1'b0;
            sat_cnt  <= '0;
        end else if (deliver_s && (|sat_lanes)) begin
            sat_flag <= 1'b1;
            sat_cnt  <= (sat_cnt == CNT_MAX) ? sat_cnt : sat_cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            sat_flag <= sat_flag;
            sat_cnt  <= sat_cnt;
        end
    end

endmodule
